fifo_flagged: RTL and testbench
===============================

// Module: fifo_flagged
// PURPOSE
//  Single-clock synchronous FIFO; parametrised successor of the basic push/pop FIFO.
//  Adds arbitrary (non-power-of-2) depth, a fill-level output, programmable
//  almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow flags.
//  Buffers bytes/words between producers (e.g. framebuffer readout) and consumers (e.g. I2C
//  byte sender) where back-pressure must be seen before the FIFO is completely full.
// PARAMETERS
//  DATA_WIDTH  8   width of din/dout
//  DEPTH       4   number of entries, any integer >= 2 (power of 2 not required)
//  AF_LEVEL    3   almost_full asserted when level >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL    1   almost_empty asserted when level <= AE_LEVEL (0..DEPTH-1)
//  LW = $clog2(DEPTH+1) (localparam, level width)
// PORTS
//  clk           in   1           rising-edge clock
//  reset         in   1           asynchronous, active-high reset
//  din           in   DATA_WIDTH  write data
//  push          in   1           write request
//  pop           in   1           read request
//  flush         in   1           synchronous clear of contents
//  err_clr       in   1           clears overflow/underflow
//  dout          out  DATA_WIDTH  head-of-queue data (show-ahead)
//  full          out  1           level == DEPTH
//  empty         out  1           level == 0
//  almost_full   out  1           level >= AF_LEVEL
//  almost_empty  out  1           level <= AE_LEVEL
//  level         out  LW          number of stored entries
//  overflow      out  1           sticky: push rejected
//  underflow     out  1           sticky: pop rejected
// BEHAVIOUR
//  - Reset (async, immediate): rd_ptr=wr_ptr=0, level=0, overflow=underflow=0 ->
//    empty=1, full=0, almost_full=0, almost_empty=1. Storage array not reset.
//  - Show-ahead: dout = mem[rd_ptr] combinationally; valid only while empty=0; X/stale when empty.
//  - pop_ok  = pop & ~empty.  push_ok = push & (~full | pop_ok).
//  - push_ok: mem[wr_ptr]<=din; wr_ptr advances. pop_ok: rd_ptr advances.
//  - Pointer wrap: ptr==DEPTH-1 -> 0, else ptr+1 (explicit compare, no modulo-2^n wrap).
//  - level: +1 on push_ok only, -1 on pop_ok only, unchanged on both/neither.
//  - Full + push + pop: both accepted, level stays DEPTH, no overflow.
//  - Empty + push + pop: pop rejected (underflow set), push accepted, level 0->1.
//  - overflow <= 1 when push & ~push_ok; underflow <= 1 when pop & ~pop_ok.
//  - err_clr clears both flags; a new error in the same cycle wins (flag stays/sets 1).
//  - flush (priority over push/pop): next cycle pointers=0, level=0; push/pop that cycle
//    ignored and do NOT set error flags; error flags otherwise untouched by flush.
//  - All status outputs are combinational decodes of registered level; they reflect an
//    accepted operation on the cycle after the clock edge, never within the same cycle.
//  - Reset mid-operation: all state reverts immediately; stored data considered lost.
// TESTING  (DATA_WIDTH=8, DEPTH=5, AF_LEVEL=4, AE_LEVEL=1 unless noted)
//  1 Reset released, push 0x11..0x15 on 5 cycles -> level 1..5, almost_empty drops at
//    level 2, almost_full at 4, full at 5; dout=0x11 throughout; overflow=0.
//  2 From full, push 0x66 alone -> overflow=1, level=5, contents unchanged; then pop x5 ->
//    dout 0x11,0x12,0x13,0x14,0x15, then empty=1; err_clr -> overflow=0.
//  3 Wrap: 100 cycles random push/pop vs scoreboard model, DEPTH=5 (non-pow2) and DEPTH=4
//    -> every popped word matches model, level matches, no spurious flags.
//  4 Full + push 0xA0 + pop same cycle -> dout advances, level stays 5, overflow=0;
//    empty + push 0xB0 + pop -> underflow=1, level=1, dout=0xB0.
//  5 level=3, flush with push=pop=1 -> next cycle level=0, empty=1, no flag change;
//    then push 0xC3 -> dout=0xC3.
//  6 Assert reset asynchronously mid-burst (between edges) -> empty=1, level=0, flags=0
//    immediately, before the next clk edge.

Source files
------------

// File: rtl/fifo_flagged.sv
// Single-clock show-ahead FIFO with any depth, fill level, almost-full/empty thresholds, flush and sticky error flags.
// Accepted push/pop shows up in status one cycle later; a push into a full FIFO only gets in alongside a pop.
module fifo_flagged #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int AF_LEVEL   = 3,
   parameter int AE_LEVEL   = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [DATA_WIDTH-1:0]        din,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  logic                         err_clr,
   output logic [DATA_WIDTH-1:0]        dout,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int LW = $clog2(DEPTH+1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH-1);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [LW-1:0] AF_LVL   = LW'(AF_LEVEL);
   localparam logic [LW-1:0] AE_LVL   = LW'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_rd_ptr;
   logic [PW-1:0]         r_wr_ptr;
   logic [LW-1:0]         r_level;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_pop_ok;
   logic                  w_push_ok;
   logic [PW-1:0]         w_rd_nxt;
   logic [PW-1:0]         w_wr_nxt;

   assign w_full    = (r_level == FULL_LVL);
   assign w_empty   = (r_level == '0);
   assign w_pop_ok  = pop & ~w_empty;
   // A full FIFO still takes a push when a pop frees the head slot in the same cycle.
   assign w_push_ok = push & (~w_full | w_pop_ok);

   assign w_rd_nxt  = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
   assign w_wr_nxt  = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_level  <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= w_wr_nxt;
         if (w_pop_ok)  r_rd_ptr <= w_rd_nxt;
         if (w_push_ok & ~w_pop_ok)
            r_level <= r_level + LW'(1);
         else if (w_pop_ok & ~w_push_ok)
            r_level <= r_level - LW'(1);
      end
   end

   // Flush suppresses new errors but leaves existing flags alone; a fresh error beats err_clr.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= (~flush & push & ~w_push_ok) | (r_overflow  & ~err_clr);
         r_underflow <= (~flush & pop  & ~w_pop_ok)  | (r_underflow & ~err_clr);
      end
   end

   always_ff @(posedge clk) begin
      if (~flush & w_push_ok)
         r_mem[r_wr_ptr] <= din;
   end

   assign dout         = r_mem[r_rd_ptr];
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_level >= AF_LVL);
   assign almost_empty = (r_level <= AE_LVL);
   assign level        = r_level;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_flagged.sv
// Bench for fifo_flagged: a DEPTH=5 and a DEPTH=4 instance share stimulus, each tracked by its own queue model.
module tb_fifo_flagged;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] din;
   logic       push, pop, flush, err_clr;

   logic [7:0] dout5, dout4;
   logic       full5, empty5, af5, ae5, ov5, un5;
   logic       full4, empty4, af4, ae4, ov4, un4;
   logic [2:0] level5, level4;
   logic [5:0] st5, st4;

   int checks = 0;
   int errors = 0;

   logic [7:0] q5[$];
   logic [7:0] q4[$];
   logic       m_ov5, m_un5, m_ov4, m_un4;

   assign st5 = {full5, empty5, af5, ae5, ov5, un5};
   assign st4 = {full4, empty4, af4, ae4, ov4, un4};

   always #5 clk = ~clk;

   fifo_flagged #(.DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_d5 (
      .clk(clk), .reset(reset), .din(din), .push(push), .pop(pop), .flush(flush),
      .err_clr(err_clr), .dout(dout5), .full(full5), .empty(empty5), .almost_full(af5),
      .almost_empty(ae5), .level(level5), .overflow(ov5), .underflow(un5));

   fifo_flagged #(.DATA_WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) u_d4 (
      .clk(clk), .reset(reset), .din(din), .push(push), .pop(pop), .flush(flush),
      .err_clr(err_clr), .dout(dout4), .full(full4), .empty(empty4), .almost_full(af4),
      .almost_empty(ae4), .level(level4), .overflow(ov4), .underflow(un4));

   task automatic set_in(input logic p, input logic q, input logic [7:0] d,
                         input logic f, input logic e);
      push = p; pop = q; din = d; flush = f; err_clr = e;
   endtask

   // Advance both reference models with the current inputs, then clock once.
   task automatic step();
      logic pok, wok;
      if (flush) begin
         q5.delete(); q4.delete();
         if (err_clr) begin m_ov5 = 0; m_un5 = 0; m_ov4 = 0; m_un4 = 0; end
      end else begin
         pok = pop && (q5.size() > 0);
         wok = push && ((q5.size() < 5) || pok);
         m_ov5 = (push && !wok) || (m_ov5 && !err_clr);
         m_un5 = (pop && !pok) || (m_un5 && !err_clr);
         if (pok) void'(q5.pop_front());
         if (wok) q5.push_back(din);
         pok = pop && (q4.size() > 0);
         wok = push && ((q4.size() < 4) || pok);
         m_ov4 = (push && !wok) || (m_ov4 && !err_clr);
         m_un4 = (pop && !pok) || (m_un4 && !err_clr);
         if (pok) void'(q4.pop_front());
         if (wok) q4.push_back(din);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      checks++; if (st5 !== 6'b010100) begin errors++; $display("FAIL reset_status5 got %b want %b", st5, 6'b010100); end
      checks++; if (level5 !== 3'd0) begin errors++; $display("FAIL reset_level5 got %0d want 0", level5); end
      checks++; if (st4 !== 6'b010100) begin errors++; $display("FAIL reset_status4 got %b want %b", st4, 6'b010100); end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_fill();
      logic [2:0] lvl;
      logic [5:0] exp;
      for (int i = 0; i < 5; i++) begin
         set_in(1, 0, 8'h11 + 8'(i), 0, 0);
         step();
         lvl = 3'(i + 1);
         exp = {lvl == 3'd5, 1'b0, lvl >= 3'd4, lvl <= 3'd1, 2'b00};
         checks++; if (level5 !== lvl) begin errors++; $display("FAIL fill_level got %0d want %0d", level5, lvl); end
         checks++; if (st5 !== exp) begin errors++; $display("FAIL fill_status got %b want %b", st5, exp); end
         checks++; if (dout5 !== 8'h11) begin errors++; $display("FAIL fill_dout got %h want 11", dout5); end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] exp;
      set_in(1, 0, 8'h66, 0, 0);
      step();
      checks++; if (ov5 !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", ov5); end
      checks++; if (level5 !== 3'd5) begin errors++; $display("FAIL ovf_level got %0d want 5", level5); end
      checks++; if (dout5 !== 8'h11) begin errors++; $display("FAIL ovf_dout got %h want 11", dout5); end
      for (int i = 0; i < 5; i++) begin
         set_in(0, 1, 8'h00, 0, 0);
         exp = q5[0];
         checks++; if (dout5 !== exp || exp !== 8'h11 + 8'(i)) begin errors++; $display("FAIL drain_dout got %h want %h", dout5, 8'h11 + 8'(i)); end
         step();
      end
      set_in(0, 0, 8'h00, 0, 0);
      checks++; if (empty5 !== 1'b1 || un5 !== 1'b0) begin errors++; $display("FAIL drain_empty got e=%b u=%b want e=1 u=0", empty5, un5); end
      set_in(0, 0, 8'h00, 0, 1);
      step();
      set_in(0, 0, 8'h00, 0, 0);
      checks++; if (ov5 !== 1'b0) begin errors++; $display("FAIL err_clr got %b want 0", ov5); end
   endtask

   task automatic test_wrap();
      set_in(0, 0, 8'h00, 1, 1);
      step();
      for (int c = 0; c < 100; c++) begin
         set_in(32'($urandom_range(0, 99)) < (c < 50 ? 70 : 35),
                32'($urandom_range(0, 99)) < (c < 50 ? 35 : 70),
                8'($urandom), 0, (c % 25) == 24);
         if (pop && q5.size() > 0) begin
            checks++; if (dout5 !== q5[0]) begin errors++; $display("FAIL wrap_dout5 got %h want %h", dout5, q5[0]); end
         end
         if (pop && q4.size() > 0) begin
            checks++; if (dout4 !== q4[0]) begin errors++; $display("FAIL wrap_dout4 got %h want %h", dout4, q4[0]); end
         end
         step();
         checks++; if (level5 !== 3'(q5.size()) || {ov5, un5} !== {m_ov5, m_un5}) begin
            errors++; $display("FAIL wrap_state5 got l=%0d o=%b u=%b want l=%0d o=%b u=%b", level5, ov5, un5, q5.size(), m_ov5, m_un5); end
         checks++; if (level4 !== 3'(q4.size()) || {ov4, un4} !== {m_ov4, m_un4}) begin
            errors++; $display("FAIL wrap_state4 got l=%0d o=%b u=%b want l=%0d o=%b u=%b", level4, ov4, un4, q4.size(), m_ov4, m_un4); end
      end
   endtask

   task automatic test_simul();
      set_in(0, 0, 8'h00, 1, 1);
      step();
      for (int i = 0; i < 5; i++) begin
         set_in(1, 0, 8'h21 + 8'(i), 0, 0);
         step();
      end
      set_in(1, 1, 8'hA0, 0, 0);
      checks++; if (dout5 !== q5[0]) begin errors++; $display("FAIL full_pp_head got %h want %h", dout5, q5[0]); end
      step();
      checks++; if (level5 !== 3'd5 || ov5 !== 1'b0) begin errors++; $display("FAIL full_pp_state got l=%0d o=%b want l=5 o=0", level5, ov5); end
      checks++; if (dout5 !== 8'h22) begin errors++; $display("FAIL full_pp_dout got %h want 22", dout5); end
      set_in(0, 0, 8'h00, 1, 0);
      step();
      set_in(1, 1, 8'hB0, 0, 0);
      step();
      set_in(0, 0, 8'h00, 0, 0);
      checks++; if (un5 !== 1'b1 || level5 !== 3'd1) begin errors++; $display("FAIL empty_pp_state got u=%b l=%0d want u=1 l=1", un5, level5); end
      checks++; if (dout5 !== 8'hB0) begin errors++; $display("FAIL empty_pp_dout got %h want b0", dout5); end
   endtask

   task automatic test_flush();
      set_in(1, 0, 8'hD2, 0, 0); step();
      set_in(1, 0, 8'hD3, 0, 0); step();
      checks++; if (level5 !== 3'd3) begin errors++; $display("FAIL pre_flush_level got %0d want 3", level5); end
      set_in(1, 1, 8'hEE, 1, 0);
      step();
      set_in(0, 0, 8'h00, 0, 0);
      checks++; if (level5 !== 3'd0 || empty5 !== 1'b1) begin errors++; $display("FAIL flush_state got l=%0d e=%b want l=0 e=1", level5, empty5); end
      checks++; if ({ov5, un5} !== 2'b01) begin errors++; $display("FAIL flush_flags got %b want 01", {ov5, un5}); end
      set_in(1, 0, 8'hC3, 0, 0);
      step();
      set_in(0, 0, 8'h00, 0, 0);
      checks++; if (dout5 !== 8'hC3 || level5 !== 3'd1) begin errors++; $display("FAIL post_flush got d=%h l=%0d want d=c3 l=1", dout5, level5); end
   endtask

   task automatic test_async_reset();
      set_in(1, 0, 8'hE1, 0, 0); step();
      set_in(1, 0, 8'hE2, 0, 0); step();
      set_in(1, 1, 8'hE3, 0, 0);
      #2 reset = 1'b1;
      #1;
      checks++; if (st5 !== 6'b010100 || level5 !== 3'd0) begin errors++; $display("FAIL async_reset5 got s=%b l=%0d want s=010100 l=0", st5, level5); end
      checks++; if (st4 !== 6'b010100 || level4 !== 3'd0) begin errors++; $display("FAIL async_reset4 got s=%b l=%0d want s=010100 l=0", st4, level4); end
      q5.delete(); q4.delete();
      m_ov5 = 0; m_un5 = 0; m_ov4 = 0; m_un4 = 0;
      set_in(0, 0, 8'h00, 0, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      set_in(1, 0, 8'h5A, 0, 0);
      step();
      set_in(0, 0, 8'h00, 0, 0);
      checks++; if (dout5 !== 8'h5A || level5 !== 3'd1) begin errors++; $display("FAIL after_reset got d=%h l=%0d want d=5a l=1", dout5, level5); end
   endtask

   initial begin
      reset = 1'b1;
      set_in(0, 0, 8'h00, 0, 0);
      m_ov5 = 0; m_un5 = 0; m_ov4 = 0; m_un4 = 0;
      #1;
      test_reset();
      test_fill();
      test_overflow();
      test_wrap();
      test_simul();
      test_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
